axi4_burst_seq: RTL and testbench

- Burst sequencer for the AXI4 slave side.
- Accepts one AR/AW command and expands it into a stream of per-beat addresses, sequencing the shared axi4_addr_gen next-address datapath.
- Provides beat index, last flag and an illegal-burst flag to downstream R/W datapaths such as SRAM or register bridges.
- Sits between the AXI4 address-channel skid buffer and the beat-level memory interface.

---
 rtl/axi4_burst_seq_pkg.sv | 41 ++++
 rtl/axi4_burst_seq_if.sv | 35 +++
 rtl/axi4_burst_seq_addr_gen.sv | 38 +++
 rtl/axi4_burst_seq.sv | 100 ++++++++++
 tb/tb_axi4_burst_seq.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_burst_seq_pkg.sv
// Shared AXI4 constants, burst encodings, sequencer state and stored-command types.
package axi4_burst_seq_pkg;

  // Width of the in-page offset that address generation operates on (4 KiB page).
  localparam int unsigned AXI4_ADDR_OFT_WIDTH = 12;
  // Widest AXI ID a stored command can carry.
  localparam int unsigned AXI4_MAX_ID_WIDTH   = 16;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi4_burst_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [AXI4_MAX_ID_WIDTH-1:0] id;
    logic [7:0]                   len;
    logic [2:0]                   size;
    axi4_burst_e                  burst;
    logic                         err;
  } seq_cmd_t;

  // A burst is illegal for a bad WRAP length, an oversize beat or the reserved type.
  function automatic logic burst_illegal(input logic [7:0]  len,
                                         input logic [2:0]  size,
                                         input axi4_burst_e burst,
                                         input int unsigned data_bytes);
    logic wrap_bad;
    logic size_bad;
    wrap_bad = (burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    size_bad = (32'd1 << size) > data_bytes;
    return wrap_bad || size_bad || (burst == BURST_RSVD);
  endfunction

endpackage

// File: rtl/axi4_burst_seq_if.sv
// Command and beat channels of the AXI4 burst sequencer.
interface axi4_burst_seq_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  logic                  avalid_i;
  logic                  aready_o;
  logic [ID_WIDTH-1:0]   aid_i;
  logic [ADDR_WIDTH-1:0] aaddr_i;
  logic [7:0]            alen_i;
  logic [2:0]            asize_i;
  logic [1:0]            aburst_i;
  logic                  beat_valid_o;
  logic                  beat_ready_i;
  logic [ADDR_WIDTH-1:0] beat_addr_o;
  logic [ID_WIDTH-1:0]   beat_id_o;
  logic [7:0]            beat_idx_o;
  logic                  beat_last_o;
  logic                  beat_err_o;
  logic                  busy_o;

  // Sequencer side.
  modport slave (
    input  avalid_i, aid_i, aaddr_i, alen_i, asize_i, aburst_i, beat_ready_i,
    output aready_o, beat_valid_o, beat_addr_o, beat_id_o, beat_idx_o,
           beat_last_o, beat_err_o, busy_o
  );

  // Command source / beat consumer side.
  modport master (
    output avalid_i, aid_i, aaddr_i, alen_i, asize_i, aburst_i, beat_ready_i,
    input  aready_o, beat_valid_o, beat_addr_o, beat_id_o, beat_idx_o,
           beat_last_o, beat_err_o, busy_o
  );
endinterface

// File: rtl/axi4_burst_seq_addr_gen.sv
// Next-beat address on the in-page offset bits for FIXED/INCR/WRAP bursts.
module axi4_addr_gen
  import axi4_burst_seq_pkg::*;
#(
  parameter int unsigned OFT_WIDTH = AXI4_ADDR_OFT_WIDTH
) (
  input  logic [OFT_WIDTH-1:0] addr_i,
  input  logic [7:0]           len_i,
  input  logic [2:0]           size_i,
  input  axi4_burst_e          burst_i,
  output logic [OFT_WIDTH-1:0] next_addr_o
);

  localparam logic [OFT_WIDTH-1:0] ONE = OFT_WIDTH'(1);

  logic [OFT_WIDTH-1:0] bytes;
  logic [OFT_WIDTH-1:0] aligned;
  logic [OFT_WIDTH-1:0] incr;
  logic [OFT_WIDTH-1:0] mask;
  logic [15:0]          wrap_bytes;

  // Align to the beat size, step one beat, and fold into the wrap window for WRAP.
  always_comb begin
    bytes       = ONE << size_i;
    aligned     = addr_i & ~(bytes - ONE);
    incr        = aligned + bytes;
    wrap_bytes  = ({8'd0, len_i} + 16'd1) << size_i;
    mask        = wrap_bytes[OFT_WIDTH-1:0] - ONE;
    next_addr_o = incr;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incr;
      BURST_WRAP:  next_addr_o = (addr_i & ~mask) | (incr & mask);
      default:     next_addr_o = incr;
    endcase
  end

endmodule

// File: rtl/axi4_burst_seq.sv
// AXI4 slave burst sequencer: expands one AR/AW command into per-beat addresses.
module axi4_burst_seq
  import axi4_burst_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_BYTES = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  axi4_burst_seq_if.slave  bus
);

  localparam int unsigned OFT_W = AXI4_ADDR_OFT_WIDTH;

  seq_state_e            state_q, state_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            idx_q, idx_d;
  seq_cmd_t              cmd_q, cmd_d;

  logic                  beat_hs;
  logic                  beat_last;
  logic                  aready;
  logic                  cmd_acc;
  logic [OFT_W-1:0]      next_oft;
  logic                  unused_id;

  assign beat_last = valid_q && (idx_q == cmd_q.len);
  assign beat_hs   = valid_q && bus.beat_ready_i;
  // Accepting while the last beat retires keeps back-to-back bursts bubble-free.
  assign aready    = (state_q == ST_IDLE) || (beat_hs && beat_last);
  assign cmd_acc   = bus.avalid_i && aready;
  assign unused_id = ^cmd_q.id;

  axi4_addr_gen #(
    .OFT_WIDTH (OFT_W)
  ) u_addr_gen (
    .addr_i      (addr_q[OFT_W-1:0]),
    .len_i       (cmd_q.len),
    .size_i      (cmd_q.size),
    .burst_i     (cmd_q.burst),
    .next_addr_o (next_oft)
  );

  // Next state: accept has priority over retiring the last beat of the current burst.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    cmd_d   = cmd_q;
    if (cmd_acc) begin
      state_d                = ST_BURST;
      valid_d                = 1'b1;
      addr_d                 = bus.aaddr_i;
      idx_d                  = '0;
      cmd_d.id               = '0;
      cmd_d.id[ID_WIDTH-1:0] = bus.aid_i;
      cmd_d.len              = bus.alen_i;
      cmd_d.size             = bus.asize_i;
      cmd_d.burst            = axi4_burst_e'(bus.aburst_i);
      cmd_d.err              = burst_illegal(bus.alen_i, bus.asize_i,
                                             axi4_burst_e'(bus.aburst_i), DATA_BYTES);
    end else if (beat_hs && beat_last) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else if (beat_hs) begin
      idx_d              = idx_q + 8'd1;
      addr_d[OFT_W-1:0]  = next_oft;
    end
  end

  // State and registered beat outputs with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
    end
  end

  assign bus.aready_o     = aready;
  assign bus.beat_valid_o = valid_q;
  assign bus.beat_addr_o  = addr_q;
  assign bus.beat_id_o    = cmd_q.id[ID_WIDTH-1:0];
  assign bus.beat_idx_o   = idx_q;
  assign bus.beat_last_o  = beat_last;
  assign bus.beat_err_o   = cmd_q.err;
  assign bus.busy_o       = (state_q == ST_BURST);

endmodule

// File: tb/tb_axi4_burst_seq.sv
// Self-checking bench for axi4_burst_seq: directed cases plus randomized bursts vs. a beat-list model.
module tb_axi4_burst_seq;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4_burst_seq_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axi4_burst_seq #(
    .ADDR_WIDTH (AW),
    .ID_WIDTH   (IW),
    .DATA_BYTES (8)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  idx;
    logic        last;
    logic        err;
    int          cyc;
  } beat_t;

  beat_t expq[$];
  beat_t blog[$];
  int    acc_cyc   = 0;
  logic  after_rst = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Address of beat n worked out directly from the burst rules.
  function automatic logic [31:0] model_addr(input logic [31:0] a, input int unsigned len,
                                             input int unsigned size, input int unsigned bt,
                                             input int unsigned n);
    int unsigned bytes, page, off, al, wsz, wb;
    bytes = 32'd1 << size;
    page  = a & 32'hFFFF_F000;
    off   = a & 32'h0000_0FFF;
    al    = off & ~(bytes - 1);
    if (n == 0 || bt == 0) return a;
    if (bt == 2) begin
      wsz = (len + 1) * bytes;
      wb  = off - (off % wsz);
      return page | (wb + ((al - wb + n * bytes) % wsz));
    end
    return page | ((al + n * bytes) & 32'h0000_0FFF);
  endfunction

  function automatic logic model_err(input int unsigned len, input int unsigned size,
                                     input int unsigned bt);
    logic wrap_ok;
    wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
    return (bt == 3) || ((32'd1 << size) > 8) || (bt == 2 && !wrap_ok);
  endfunction

  // Per-cycle comparison against the beat-list model, then model update for the coming edge.
  always @(negedge clk) begin
    logic  ev, exp_ar;
    beat_t e, b;
    if (!rst_n) begin
      expq.delete();
      after_rst = 1'b1;
    end else begin
      ev     = (expq.size() != 0);
      exp_ar = !ev || (bus.beat_ready_i && expq[0].last);
      chk("beat_valid", 32'(bus.beat_valid_o), 32'(ev));
      chk("busy", 32'(bus.busy_o), 32'(ev));
      chk("aready", 32'(bus.aready_o), 32'(exp_ar));
      if (after_rst) begin
        chk("rst_addr", bus.beat_addr_o, 32'h0);
        chk("rst_id", 32'(bus.beat_id_o), 32'h0);
        chk("rst_idx", 32'(bus.beat_idx_o), 32'h0);
        chk("rst_last", 32'(bus.beat_last_o), 32'h0);
        chk("rst_err", 32'(bus.beat_err_o), 32'h0);
        after_rst = 1'b0;
      end else if (ev) begin
        chk("beat_id", 32'(bus.beat_id_o), 32'(expq[0].id));
        chk("beat_idx", 32'(bus.beat_idx_o), 32'(expq[0].idx));
        chk("beat_last", 32'(bus.beat_last_o), 32'(expq[0].last));
        chk("beat_err", 32'(bus.beat_err_o), 32'(expq[0].err));
        if (!expq[0].err) chk("beat_addr", bus.beat_addr_o, expq[0].addr);
      end else begin
        chk("idle_last", 32'(bus.beat_last_o), 32'h0);
      end
      if (bus.beat_valid_o && bus.beat_ready_i) begin
        b.addr = bus.beat_addr_o; b.id = bus.beat_id_o; b.idx = bus.beat_idx_o;
        b.last = bus.beat_last_o; b.err = bus.beat_err_o; b.cyc = cyc;
        blog.push_back(b);
      end
      if (ev && bus.beat_ready_i) void'(expq.pop_front());
      if (bus.avalid_i && exp_ar) begin
        for (int unsigned n = 0; n <= 32'(bus.alen_i); n++) begin
          e.addr = model_addr(bus.aaddr_i, 32'(bus.alen_i), 32'(bus.asize_i), 32'(bus.aburst_i), n);
          e.id   = bus.aid_i;
          e.idx  = 8'(n);
          e.last = (n == 32'(bus.alen_i));
          e.err  = model_err(32'(bus.alen_i), 32'(bus.asize_i), 32'(bus.aburst_i));
          e.cyc  = 0;
          expq.push_back(e);
        end
        acc_cyc = cyc;
      end
    end
  end

  // beat_ready_i generator: 0 always ready, 1 random, 2 scripted pattern, other held low.
  int   rmode = 0;
  int   pidx  = 0;
  logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  always @(posedge clk) begin
    #2;
    case (rmode)
      0: bus.beat_ready_i = 1'b1;
      1: bus.beat_ready_i = 1'($urandom_range(0, 1));
      2: begin
        if (pidx < 5) begin
          bus.beat_ready_i = pat[pidx];
          pidx++;
        end else begin
          bus.beat_ready_i = 1'b1;
        end
      end
      default: bus.beat_ready_i = 1'b0;
    endcase
  end

  task automatic send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                      input logic [2:0] sz, input logic [1:0] bt);
    logic hit;
    hit = 1'b0;
    bus.aid_i = id; bus.aaddr_i = a; bus.alen_i = len; bus.asize_i = sz; bus.aburst_i = bt;
    bus.avalid_i = 1'b1;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      hit = bus.aready_o;
      @(posedge clk);
      #1;
    end
    bus.avalid_i = 1'b0;
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=0 exp=1 addr=%0h", a);
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 4000 && !done; n++) begin
      @(posedge clk);
      #1;
      done = (expq.size() == 0) && !bus.beat_valid_o;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
  endtask

  // Compare logged handshakes of one burst against literal expectations.
  task automatic chk_beats(input string nm, input int base, input int n,
                           input logic [31:0] addrs [8], input logic chk_addr,
                           input logic err);
    checks++;
    if (blog.size() < base + n) begin
      errors++;
      $display("FAIL %s_count got=%0d exp=%0d", nm, blog.size() - base, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (chk_addr) chk({nm, "_addr"}, blog[base+i].addr, addrs[i]);
        chk({nm, "_idx"}, 32'(blog[base+i].idx), 32'(i));
        chk({nm, "_last"}, 32'(blog[base+i].last), 32'(i == n - 1));
        chk({nm, "_err"}, 32'(blog[base+i].err), 32'(err));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, a0;
    logic [31:0] ea [8];
    bus.avalid_i = 1'b0; bus.aid_i = '0; bus.aaddr_i = '0;
    bus.alen_i = '0; bus.asize_i = '0; bus.aburst_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // INCR 0x100, 4 beats of 4 bytes, always ready.
    base = blog.size();
    send(4'd1, 32'h100, 8'd3, 3'd2, 2'b01);
    a0 = acc_cyc;
    wait_idle();
    ea = '{32'h100, 32'h104, 32'h108, 32'h10C, 0, 0, 0, 0};
    chk_beats("incr", base, 4, ea, 1'b1, 1'b0);
    if (blog.size() >= base + 4) begin
      chk("incr_latency", 32'(blog[base].cyc), 32'(a0 + 1));
      chk("incr_nobubble", 32'(blog[base+3].cyc), 32'(a0 + 4));
    end

    // WRAP legal and illegal length.
    base = blog.size();
    send(4'd2, 32'h108, 8'd3, 3'd2, 2'b10);
    wait_idle();
    ea = '{32'h108, 32'h10C, 32'h100, 32'h104, 0, 0, 0, 0};
    chk_beats("wrap", base, 4, ea, 1'b1, 1'b0);
    base = blog.size();
    send(4'd3, 32'h108, 8'd2, 3'd2, 2'b10);
    wait_idle();
    chk_beats("wrap_bad", base, 3, ea, 1'b0, 1'b1);

    // FIXED with stalls: ready 1,0,0,1,1 from the first beat cycle.
    rmode = 3;
    base = blog.size();
    send(4'd4, 32'h20, 8'd2, 3'd2, 2'b00);
    a0 = acc_cyc;
    pidx = 0;
    rmode = 2;
    wait_idle();
    rmode = 0;
    ea = '{32'h20, 32'h20, 32'h20, 0, 0, 0, 0, 0};
    chk_beats("fixed", base, 3, ea, 1'b1, 1'b0);
    if (blog.size() >= base + 3) begin
      chk("fixed_cyc1", 32'(blog[base+1].cyc), 32'(a0 + 4));
      chk("fixed_cyc2", 32'(blog[base+2].cyc), 32'(a0 + 5));
    end

    // Back-to-back bursts with no bubble.
    base = blog.size();
    send(4'd1, 32'h40, 8'd0, 3'd2, 2'b01);
    send(4'd2, 32'h80, 8'd1, 3'd2, 2'b01);
    wait_idle();
    checks++;
    if (blog.size() < base + 3) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=3", blog.size() - base);
    end else begin
      chk("b2b_a0", blog[base].addr, 32'h40);
      chk("b2b_a1", blog[base+1].addr, 32'h80);
      chk("b2b_a2", blog[base+2].addr, 32'h84);
      chk("b2b_id0", 32'(blog[base].id), 32'd1);
      chk("b2b_id2", 32'(blog[base+2].id), 32'd2);
      chk("b2b_last0", 32'(blog[base].last), 32'd1);
      chk("b2b_last1", 32'(blog[base+1].last), 32'd0);
      chk("b2b_cyc1", 32'(blog[base+1].cyc), 32'(blog[base].cyc + 1));
      chk("b2b_cyc2", 32'(blog[base+2].cyc), 32'(blog[base].cyc + 2));
    end

    // INCR across the page end stays in the page.
    base = blog.size();
    send(4'd5, 32'h0000_1FFC, 8'd1, 3'd2, 2'b01);
    wait_idle();
    ea = '{32'h0000_1FFC, 32'h0000_1000, 0, 0, 0, 0, 0, 0};
    chk_beats("page", base, 2, ea, 1'b1, 1'b0);

    // Reset during beat 2 of an 8-beat INCR.
    base = blog.size();
    send(4'd6, 32'h200, 8'd7, 3'd2, 2'b01);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", 32'(bus.beat_valid_o), 32'd0);
    chk("rstmid_aready", 32'(bus.aready_o), 32'd1);
    chk("rstmid_busy", 32'(bus.busy_o), 32'd0);
    chk("rstmid_beats", 32'(blog.size() - base), 32'd2);
    @(posedge clk); #1;
    base = blog.size();
    send(4'd7, 32'h300, 8'd1, 3'd1, 2'b01);
    wait_idle();
    ea = '{32'h300, 32'h302, 0, 0, 0, 0, 0, 0};
    chk_beats("post_rst", base, 2, ea, 1'b1, 1'b0);

    // Randomized bursts with random back-pressure.
    rmode = 1;
    for (int k = 0; k < 80; k++) begin
      int unsigned r;
      logic [1:0]  bt;
      logic [7:0]  len;
      logic [2:0]  sz;
      r  = $urandom_range(0, 9);
      bt = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (r < 9) ? 2'b00 : 2'b11;
      if (bt == 2'b10 && $urandom_range(0, 4) != 0) begin
        r   = $urandom_range(0, 3);
        len = 8'((2 << r) - 1);
      end else begin
        len = 8'($urandom_range(0, 15));
      end
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(4'($urandom_range(0, 15)), $urandom, len, sz, bt);
    end
    wait_idle();
    rmode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
